// File: rtl/flops_pkg.sv
// rtl/flops_pkg.sv - shared mode/state enums for the universal shift register
package flops_pkg;

    typedef enum logic [2:0] {
        HOLD = 3'd0,
        LOAD = 3'd1,
        SHL  = 3'd2,
        SHR  = 3'd3,
        ROL  = 3'd4,
        ROR  = 3'd5,
        ASR  = 3'd6,
        RSV7 = 3'd7
    } mode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    // Modes that move bits and therefore update sout and may be bursted.
    function automatic logic is_shift(mode_e m);
        return (m == SHL) || (m == SHR) || (m == ROL) || (m == ROR) || (m == ASR);
    endfunction

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational single-step shift/rotate next-value logic
module shift_step
    import flops_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  mode_e            mode,
    input  logic             sin,
    output logic [WIDTH-1:0] q_next,
    output logic             sout_next
);

    // HOLD/LOAD/RSV7 pass q through; the top handles parallel load.
    always_comb begin
        q_next    = q;
        sout_next = 1'b0;
        case (mode)
            SHL: begin
                q_next    = {q[WIDTH-2:0], sin};
                sout_next = q[WIDTH-1];
            end
            SHR: begin
                q_next    = {sin, q[WIDTH-1:1]};
                sout_next = q[0];
            end
            ROL: begin
                q_next    = {q[WIDTH-2:0], q[WIDTH-1]};
                sout_next = q[WIDTH-1];
            end
            ROR: begin
                q_next    = {q[0], q[WIDTH-1:1]};
                sout_next = q[0];
            end
            ASR: begin
                q_next    = {q[WIDTH-1], q[WIDTH-1:1]};
                sout_next = q[0];
            end
            default: begin
                q_next    = q;
                sout_next = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register with single-step and counted burst modes
module univ_shift_reg
    import flops_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int               CW      = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  mode_e            mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    input  logic             start,
    input  logic [CW-1:0]    cnt,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             sout_q, sout_d;
    logic             done_q, done_d;

    mode_e            step_mode;
    logic             do_step;
    logic [WIDTH-1:0] step_q;
    logic             step_sout;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .q         (q_q),
        .mode      (step_mode),
        .sin       (sin),
        .q_next    (step_q),
        .sout_next (step_sout)
    );

    // cnt_q holds the steps still owed after the current edge.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        q_d       = q_q;
        sout_d    = sout_q;
        done_d    = 1'b0;
        step_mode = mode;
        do_step   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && is_shift(mode) && (cnt != '0)) begin
                    do_step = 1'b1;
                    mode_d  = mode;
                    if (cnt > CW'(1)) begin
                        state_d = BURST;
                        cnt_d   = cnt - CW'(1);
                    end else begin
                        done_d = 1'b1;
                        cnt_d  = '0;
                    end
                end else if (start || en) begin
                    do_step = 1'b1;
                end
            end
            BURST: begin
                step_mode = mode_q;
                do_step   = 1'b1;
                cnt_d     = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_step) begin
            if (step_mode == LOAD) begin
                q_d = d;
            end else begin
                q_d = step_q;
            end
            if (is_shift(step_mode)) begin
                sout_d = step_sout;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= HOLD;
            cnt_q   <= '0;
            q_q     <= RST_VAL;
            sout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            sout_q  <= sout_d;
            done_q  <= done_d;
        end
    end

    assign q    = q_q;
    assign sout = sout_q;
    assign busy = (state_q == BURST);
    assign done = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - self-checking bench for univ_shift_reg against a behavioural model
module tb_univ_shift_reg;
    import flops_pkg::*;

    logic       clk;
    logic       rst;
    logic       en;
    mode_e      mode;
    logic [7:0] d;
    logic       sin;
    logic       start;
    logic [3:0] cnt;
    logic [7:0] q, q_a5;
    logic       sout, busy, done;
    logic       sout_a5, busy_a5, done_a5;

    int vectors = 0;
    int errors  = 0;

    // Reference model: register value, last shifted-out bit, steps still owed.
    int m_q, m_sout, m_rem, m_mode, m_done;

    univ_shift_reg dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .sin(sin),
        .start(start), .cnt(cnt), .q(q), .sout(sout), .busy(busy), .done(done)
    );

    univ_shift_reg #(.RST_VAL(8'hA5)) dut_a5 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .sin(sin),
        .start(start), .cnt(cnt), .q(q_a5), .sout(sout_a5), .busy(busy_a5), .done(done_a5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void mstep(int op, int s);
        case (op)
            1: m_q = int'(d);
            2: begin m_sout = (m_q >> 7) & 1; m_q = ((m_q * 2) + s) % 256; end
            3: begin m_sout = m_q % 2; m_q = (m_q / 2) + s * 128; end
            4: begin m_sout = (m_q >> 7) & 1; m_q = ((m_q * 2) % 256) + (m_q / 128); end
            5: begin m_sout = m_q % 2; m_q = (m_q / 2) + (m_q % 2) * 128; end
            6: begin m_sout = m_q % 2; m_q = (m_q / 2) + (m_q & 128); end
            default: ;
        endcase
    endfunction

    function automatic void model_edge();
        int op;
        op = int'(mode);
        m_done = 0;
        if (m_rem > 0) begin
            mstep(m_mode, int'(sin));
            m_rem--;
            if (m_rem == 0) m_done = 1;
        end else if (start && op >= 2 && op <= 6 && cnt != 0) begin
            mstep(op, int'(sin));
            m_mode = op;
            m_rem  = int'(cnt) - 1;
            if (m_rem == 0) m_done = 1;
        end else if (start || en) begin
            mstep(op, int'(sin));
        end
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".q"},    64'(q),    64'(m_q));
        check({tag, ".sout"}, 64'(sout), 64'(m_sout));
        check({tag, ".busy"}, 64'(busy), 64'(m_rem > 0));
        check({tag, ".done"}, 64'(done), 64'(m_done));
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Pulse reset between edges; outputs must react without a clock.
    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        #1;
        m_q = 0; m_sout = 0; m_rem = 0; m_done = 0;
        check_all(tag);
        check({tag, ".q_a5"}, 64'(q_a5), 64'h0A5);
        #1;
        rst = 1'b0;
    endtask

    task automatic set_in(input logic e, input mode_e m, input logic [7:0] dv,
                          input logic s, input logic st, input logic [3:0] c);
        en = e; mode = m; d = dv; sin = s; start = st; cnt = c;
    endtask

    initial begin
        rst = 1'b1;
        set_in(1'b1, SHL, 8'h00, 1'b1, 1'b0, 4'd0);
        m_q = 0; m_sout = 0; m_rem = 0; m_mode = 0; m_done = 0;
        @(posedge clk);
        #1;
        check_all("rst_held");
        check("rst_held.q_a5", 64'(q_a5), 64'h0A5);
        #1;
        rst = 1'b0;

        // Load then shift left with sin=1.
        set_in(1'b1, LOAD, 8'h96, 1'b0, 1'b0, 4'd0);
        tick("load96");
        set_in(1'b1, SHL, 8'h00, 1'b1, 1'b0, 4'd0);
        tick("shl");
        check("shl.q_const", 64'(q), 64'h2D);
        check("shl.sout_const", 64'(sout), 64'h1);

        set_in(1'b1, LOAD, 8'h96, 1'b0, 1'b0, 4'd0);
        tick("load96b");
        check("load.sout_held", 64'(sout), 64'h1);
        set_in(1'b1, ASR, 8'h00, 1'b1, 1'b0, 4'd0);
        tick("asr");
        check("asr.q_const", 64'(q), 64'hCB);
        check("asr.sout_const", 64'(sout), 64'h0);

        set_in(1'b0, SHR, 8'h00, 1'b1, 1'b0, 4'd0);
        tick("hold_en0");

        // ROL burst of 3 from 8'h81.
        set_in(1'b1, LOAD, 8'h81, 1'b0, 1'b0, 4'd0);
        tick("load81");
        set_in(1'b0, ROL, 8'hFF, 1'b0, 1'b1, 4'd3);
        tick("rol3_accept");
        check("rol3.busy1", 64'(busy), 64'h1);
        set_in(1'b1, LOAD, 8'hFF, 1'b1, 1'b1, 4'd7);
        tick("rol3_s2");
        tick("rol3_s3");
        check("rol3.q_const", 64'(q), 64'h0C);
        check("rol3.done_const", 64'(done), 64'h1);
        check("rol3.busy_low", 64'(busy), 64'h0);
        set_in(1'b0, HOLD, 8'h00, 1'b0, 1'b0, 4'd0);
        tick("rol3_after");

        // Reset in the middle of a ROR burst.
        set_in(1'b0, ROR, 8'h00, 1'b0, 1'b1, 4'd5);
        tick("ror5_s1");
        set_in(1'b0, HOLD, 8'h00, 1'b0, 1'b0, 4'd0);
        tick("ror5_s2");
        pulse_reset("ror5_abort");
        for (int i = 0; i < 4; i++) tick("ror5_post");

        // Back-to-back bursts: SHR x2 then ROL x1 in the done cycle.
        set_in(1'b1, LOAD, 8'h3C, 1'b0, 1'b0, 4'd0);
        tick("load3c");
        set_in(1'b0, SHR, 8'h00, 1'b1, 1'b1, 4'd2);
        tick("shr2_s1");
        set_in(1'b0, HOLD, 8'h00, 1'b0, 1'b0, 4'd0);
        tick("shr2_s2");
        set_in(1'b0, ROL, 8'h00, 1'b0, 1'b1, 4'd1);
        tick("rol1_b2b");
        check("rol1.done_const", 64'(done), 64'h1);
        set_in(1'b0, HOLD, 8'h00, 1'b0, 1'b0, 4'd0);
        tick("rol1_after");

        // start with cnt=0 and start with non-shift modes act as one step.
        set_in(1'b0, SHL, 8'h00, 1'b1, 1'b1, 4'd0);
        tick("cnt0_shl");
        set_in(1'b0, LOAD, 8'h5A, 1'b0, 1'b1, 4'd4);
        tick("start_load");
        set_in(1'b0, RSV7, 8'h00, 1'b1, 1'b1, 4'd4);
        tick("start_rsv7");

        // Counts beyond WIDTH.
        set_in(1'b0, ROL, 8'h00, 1'b0, 1'b1, 4'd9);
        tick("rol9");
        set_in(1'b0, HOLD, 8'h00, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 9; i++) tick("rol9_run");
        set_in(1'b0, SHL, 8'h00, 1'b1, 1'b1, 4'd15);
        tick("shl15");
        set_in(1'b0, HOLD, 8'h00, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 15; i++) tick("shl15_run");
        check("shl15.q_const", 64'(q), 64'hFF);

        // Randomized traffic with occasional asynchronous reset.
        for (int i = 0; i < 600; i++) begin
            set_in(1'($urandom), mode_e'($urandom_range(0, 7)), 8'($urandom),
                   1'($urandom), ($urandom_range(0, 5) == 0), 4'($urandom));
            tick("rand");
            if ($urandom_range(0, 60) == 0) pulse_reset("rand_rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
